// File: rtl/vga_stream_sink.sv
// vga_stream_sink
//   Accepts a 24-bit RGB Avalon-ST pixel stream and drives a VGA port.
//   Incoming pixels are buffered in a small FIFO. Each frame's start-of-packet
//   is locked to the raster origin. After an underflow or a framing error the
//   block drops pixels until the next start-of-packet and then realigns.
//
// Ports
//   clk, reset          pixel clock; synchronous active-high reset
//   sink_data           pixel {R, G, B}
//   sink_startofpacket  first pixel of a frame
//   sink_endofpacket    last pixel of a frame
//   sink_empty          unused
//   sink_valid          source offers a pixel
//   sink_ready          a pixel is accepted this cycle (FIFO not full)
//   vga_r/g/b           colour outputs
//   vga_hs, vga_vs      active-low horizontal and vertical sync
//   vga_blank_n         high during active video
//   vga_sync_n          held low
//   frame_err_cnt       saturating count of resync events
module vga_stream_sink #(
  parameter int DW         = 23,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW:0]   sink_data,
  input  logic          sink_startofpacket,
  input  logic          sink_endofpacket,
  input  logic          sink_empty,
  input  logic          sink_valid,
  output logic          sink_ready,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          vga_sync_n,
  output logic [15:0]   frame_err_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = DW + 3;

  localparam logic [HW-1:0] H_END   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LASTP = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_END   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LASTP = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  typedef enum logic [1:0] {SEEK, ALIGN, STREAM} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic unused_ok;
  assign unused_ok = sink_empty;

  // Pixel FIFO: entry is {sop, eop, data}
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, push, pop;
  logic [EW-1:0] head;
  logic          head_sop, head_eop;
  logic [DW:0]   head_data;

  assign fifo_full  = (count == FULL_C);
  assign fifo_empty = (count == '0);
  assign sink_ready = !reset && !fifo_full;
  assign push       = sink_valid && sink_ready;
  assign head       = mem[rd_ptr];
  assign head_sop   = head[EW-1];
  assign head_eop   = head[EW-2];
  assign head_data  = head[DW:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sink_startofpacket, sink_endofpacket, sink_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Stage p0: raster position
  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_p0 <= '0;
      v_p0 <= '0;
    end else if (h_p0 == H_END) begin
      h_p0 <= '0;
      v_p0 <= (v_p0 == V_END) ? '0 : v_p0 + VW'(1);
    end else begin
      h_p0 <= h_p0 + HW'(1);
    end
  end

  logic active, origin, last_px, hs_n, vs_n;
  assign active  = (h_p0 < H_ACT) && (v_p0 < V_ACT);
  assign origin  = (h_p0 == '0) && (v_p0 == '0);
  assign last_px = (h_p0 == H_LASTP) && (v_p0 == V_LASTP);
  assign hs_n    = !((h_p0 >= H_SS) && (h_p0 < H_SE));
  assign vs_n    = !((v_p0 >= V_SS) && (v_p0 < V_SE));

  state_t      state, state_nxt;
  logic        frame_err;
  logic [DW:0] pix;

  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    frame_err = 1'b0;
    pix       = '0;
    case (state)
      SEEK: begin
        if (!fifo_empty) begin
          if (head_sop) state_nxt = ALIGN;
          else          pop = 1'b1;
        end
      end
      ALIGN: begin
        if (origin && !fifo_empty) begin
          pop       = 1'b1;
          pix       = head_data;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (active) begin
          if (fifo_empty) begin
            frame_err = 1'b1;
          end else if (head_sop != origin) begin
            // SOP away from the origin, or a frame that starts without SOP;
            // leave the entry for SEEK to judge.
            frame_err = 1'b1;
          end else begin
            pop = 1'b1;
            if (head_eop != last_px) frame_err = 1'b1;
            else                     pix = head_data;
          end
        end
      end
      default: state_nxt = SEEK;
    endcase
    if (frame_err) state_nxt = SEEK;
  end

  // Stage p1: registered outputs, all aligned to the same raster position
  logic [DW:0] rgb_p1;
  logic        vld_p1, hs_p1, vs_p1;
  logic [15:0] err_cnt_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_p1     <= '0;
      vld_p1     <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
      err_cnt_p1 <= '0;
    end else begin
      rgb_p1     <= pix;
      vld_p1     <= active;
      hs_p1      <= hs_n;
      vs_p1      <= vs_n;
      if (frame_err) err_cnt_p1 <= sat_inc16(err_cnt_p1);
    end
  end

  assign vga_r         = rgb_p1[DW -: 8];
  assign vga_g         = rgb_p1[DW-8 -: 8];
  assign vga_b         = rgb_p1[DW-16 -: 8];
  assign vga_hs        = hs_p1;
  assign vga_vs        = vs_p1;
  assign vga_blank_n   = vld_p1;
  assign vga_sync_n    = 1'b0;
  assign frame_err_cnt = err_cnt_p1;

endmodule

// File: tb/tb_vga_stream_sink.sv
// Bench for vga_stream_sink using a reduced raster so whole frames fit in a
// short run. A queue-based reference model tracks FIFO contents, raster
// position and the frame-lock mode, and predicts every output each cycle.
module tb_vga_stream_sink;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int FP = HA * VA;
  localparam int DEPTH = 16;
  localparam int M_SEEK = 0, M_ALIGN = 1, M_STREAM = 2;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sink_data;
  logic        sink_startofpacket, sink_endofpacket, sink_empty, sink_valid;
  logic        sink_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [15:0] frame_err_cnt;

  vga_stream_sink #(
    .DW(23), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_startofpacket(sink_startofpacket),
    .sink_endofpacket(sink_endofpacket), .sink_empty(sink_empty),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  ent_t src_q[$];
  ent_t mq[$];
  int   t = 0;
  int   mode = M_SEEK;
  logic exp_ok = 1'b0;
  logic [23:0] exp_rgb;
  logic        exp_hs, exp_vs, exp_blank;
  logic [15:0] exp_err;
  logic rst_req = 1'b0;
  logic stall = 1'b0;
  int   stall_pct = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic add_frame(input int eop_idx);
    ent_t e;
    logic [31:0] r;
    for (int i = 0; i < FP; i++) begin
      r = $urandom;
      e.sop = (i == 0);
      e.eop = (i == eop_idx);
      e.data = r[23:0];
      src_q.push_back(e);
    end
  endtask

  task automatic add_garbage(input int n);
    ent_t e;
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      e.sop = 1'b0;
      e.eop = 1'b0;
      e.data = r[23:0];
      src_q.push_back(e);
    end
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step();
    ent_t e, dropped;
    logic [31:0] r;
    logic vld, rdy_m, act, org, lst, pop, err;
    logic [23:0] px;
    int h, v;
    if (exp_ok) begin
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
      chk("hs", 32'(vga_hs), 32'(exp_hs));
      chk("vs", 32'(vga_vs), 32'(exp_vs));
      chk("blank_n", 32'(vga_blank_n), 32'(exp_blank));
      chk("err_cnt", 32'(frame_err_cnt), 32'(exp_err));
      chk("sync_n", 32'(vga_sync_n), 32'h0);
    end
    vld = !stall && (src_q.size() > 0) && ($urandom_range(99) >= stall_pct);
    r = $urandom;
    e = vld ? src_q[0] : r[25:0];
    reset = rst_req;
    sink_valid = vld;
    sink_startofpacket = e.sop;
    sink_endofpacket = e.eop;
    sink_data = e.data;
    sink_empty = r[31];
    #1;
    rdy_m = !rst_req && (mq.size() < DEPTH);
    chk("ready", 32'(sink_ready), 32'(rdy_m));
    if (vld && rdy_m) dropped = src_q.pop_front();
    if (rst_req) begin
      mq.delete();
      t = 0;
      mode = M_SEEK;
      exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_err = '0;
      exp_ok = 1'b1;
    end else begin
      h = t % HT;
      v = (t / HT) % VT;
      act = (h < HA) && (v < VA);
      org = (h == 0) && (v == 0);
      lst = (h == HA - 1) && (v == VA - 1);
      pop = 1'b0; err = 1'b0; px = '0;
      if (mode == M_SEEK) begin
        if (mq.size() > 0) begin
          if (mq[0].sop) mode = M_ALIGN;
          else pop = 1'b1;
        end
      end else if (mode == M_ALIGN) begin
        if (org && mq.size() > 0) begin
          pop = 1'b1; px = mq[0].data; mode = M_STREAM;
        end
      end else if (act) begin
        if (mq.size() == 0) err = 1'b1;
        else if (mq[0].sop && !org) err = 1'b1;
        else if (!mq[0].sop && org) err = 1'b1;
        else begin
          pop = 1'b1;
          if (mq[0].eop && !lst) err = 1'b1;
          else if (!mq[0].eop && lst) err = 1'b1;
          else px = mq[0].data;
        end
      end
      if (err) begin
        mode = M_SEEK;
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      end
      if (pop) dropped = mq.pop_front();
      if (vld && rdy_m) mq.push_back(e);
      exp_rgb = px;
      exp_blank = act;
      exp_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      exp_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      t++;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 8000 && src_q.size() > 0; i++) step();
    chk("drain", 32'(src_q.size()), 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    run(n);
    rst_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sink_valid = 1'b0;
    sink_startofpacket = 1'b0;
    sink_endofpacket = 1'b0;
    sink_empty = 1'b0;
    sink_data = '0;
    @(negedge clk);

    // Clean frames with the source always valid
    do_reset(2);
    add_frame(FP - 1); add_frame(FP - 1); add_frame(FP - 1);
    drain();
    run(2 * FT);

    // Source stall long enough to underflow mid-frame
    add_frame(FP - 1); add_frame(FP - 1); add_frame(FP - 1);
    run(FT + 3 * HT + 2);
    stall = 1'b1;
    run(40);
    stall = 1'b0;
    drain();
    run(2 * FT);

    // EOP one pixel early, then a correct frame
    do_reset(1);
    add_frame(FP - 2); add_frame(FP - 1);
    drain();
    run(2 * FT);

    // Garbage ahead of a valid frame
    do_reset(1);
    add_garbage(3); add_frame(FP - 1); add_frame(FP - 1);
    drain();
    run(2 * FT);

    // Reset in the middle of a frame with the FIFO partly filled
    add_frame(FP - 1); add_frame(FP - 1);
    run(FT + 2 * HT + 5);
    do_reset(1);
    add_frame(FP - 1);
    drain();
    run(2 * FT);

    // Randomized source gaps and occasional framing damage
    stall_pct = 15;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(3) == 0) add_garbage($urandom_range(1, 5));
      if ($urandom_range(4) == 0) add_frame($urandom_range(FP - 1));
      else add_frame(FP - 1);
    end
    drain();
    stall_pct = 0;
    run(2 * FT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vga_stream_sink.md
# vga_stream_sink

Consumes the 24-bit RGB Avalon-ST video stream from the game pixel generator and drives a 640x480@60 VGA port. The block sits between the stream source and the DAC pins. It buffers pixels in a small FIFO and locks each frame's start-of-packet to the raster origin. It recovers from underflow or framing errors by resynchronising on the next start-of-packet.

## Interface
Parameters:
- DW, 23: pixel data MSB index; data is {R[23:16], G[15:8], B[7:0]}.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels; line total is 800.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines; frame total is 525.
- FIFO_DEPTH, 16: pixel FIFO entries; must be a power of 2.

Ports:
- clk  in  1  pixel clock, one pixel per cycle. Reset is `reset`, synchronous, active-high. Clock is `clk`.
- reset  in  1  synchronous active-high reset.
- sink_data  in  DW+1  pixel.
- sink_startofpacket  in  1  first pixel of a frame.
- sink_endofpacket  in  1  last pixel of a frame.
- sink_empty  in  1  ignored.
- sink_valid  in  1  source has a pixel.
- sink_ready  out  1  block accepts a pixel this cycle.
- vga_r, vga_g, vga_b  out  8 each  colour outputs.
- vga_hs, vga_vs  out  1 each  horizontal and vertical sync, active-low.
- vga_blank_n  out  1  high during active video.
- vga_sync_n  out  1  tied to 0.
- frame_err_cnt  out  16  saturating count of resync events.

## Operation
- Transfer occurs when sink_valid && sink_ready. Each FIFO entry is {sop, eop, data}, 26 bits.
- sink_ready = !fifo_full. It is computed from the registered FIFO count and is 0 during reset.
- A push and a pop in the same cycle leave the count unchanged. A pop while full is allowed; no push is possible while full.
- Raster counters:
  - h runs 0..799 and wraps to 0; v increments when h wraps, runs 0..524, and wraps to 0.
  - Active region is h<640 && v<480.
  - Sync is low when h is in [656,752) or v is in [490,492), respectively.
- State machine (state encoding is free):
  - SEEK: pop and discard every head entry without SOP. If the head has SOP, do not pop; go to ALIGN. Display black.
  - ALIGN: hold the SOP entry. At h==0 && v==0, pop it, display it, and go to STREAM. Display black otherwise.
  - STREAM: pop exactly one entry per active pixel; no pop during blanking.
- Error conditions in STREAM (each one displays black for that pixel, increments frame_err_cnt, and moves to SEEK):
  - FIFO empty on an active pixel (underflow).
  - Head has SOP at any active pixel other than (0,0).
  - Entry popped at (639,479) lacks EOP.
  - Entry popped before (639,479) has EOP.
- Frame boundary: a correct EOP pop at (639,479) keeps the block in STREAM. The next frame's (0,0) pixel must then carry SOP; otherwise it is an error.
- frame_err_cnt saturates at 0xFFFF.
- Reset mid-frame: FIFO is flushed, counters return to 0, state goes to SEEK, and all outputs take their reset values on the next edge.

## Timing
- Outputs are registered. vga_r/g/b, hs, vs, and blank_n for counter position (h,v) all appear one cycle after that position, so they stay mutually aligned.
- Reset values:
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, vga_sync_n = 0.
  - sink_ready = 0, frame_err_cnt = 0, h = v = 0, state = SEEK.
- First cycle after reset deasserts: sink_ready = 1 (FIFO is empty).
- Latency from sink acceptance to display is not fixed; the pixel is displayed at its raster slot.
- The minimum FIFO fill needed before (0,0) is one entry. The source must sustain 1 pixel/cycle during active lines.

## Test plan
- Reset, then stream 307200 pixels with SOP on the first and EOP on the last, valid always high: the SOP pixel appears one cycle after h=0,v=0. vga_hs is low for 96 clocks per 800-clock line. vga_vs is low for 1600 clocks per 420000-clock frame. frame_err_cnt stays 0.
- Source stalls with valid=0 for 20 cycles mid-line 100: underflow; that pixel is black, frame_err_cnt=1, state SEEK. Every subsequent non-SOP pixel is discarded, and display resumes at the next (0,0) after an SOP arrives.
- Hold valid=1 with no pop, i.e. during blanking: sink_ready drops to 0 after exactly 16 accepted pixels and rises on the cycle after the first pop.
- Frame with EOP placed on pixel 307198: frame_err_cnt increments at that pop, and the pixel at (638,479) displays black.
- 3 garbage pixels without SOP, then a valid frame: the garbage is discarded, the frame is displayed from (0,0), and frame_err_cnt=0.
- Assert reset for 1 cycle at h=300,v=200 with the FIFO holding 10 entries: the next cycle shows h=0, v=0, hs=1, vs=1, blank_n=0, rgb=0, and sink_ready=0 in the reset cycle; then 1.
